ame_matrix_accum: RTL and testbench

- Streaming upstream stage of the affine equation solver.
- Consumes per-pixel gradient samples (six affine coefficients c0..c5 plus residual r) for one block.
- Accumulates the normal-equation system A[i][j] = sum(ci*cj) and B[i] = sum(ci*r).
- Presents the result as the 6x7 matrix (column 6 = B) with an init pulse, then holds it until the solver reports done.

---
 rtl/ame_matrix_accum_pkg.sv | 27 ++
 rtl/ame_matrix_accum_mac.sv | 42 ++++
 rtl/ame_matrix_accum.sv | 125 ++++++++++++
 tb/tb_ame_matrix_accum.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ame_matrix_accum_pkg.sv
// ame_pkg: shared state encoding, pipeline constants and upper-triangle product index tables.
package ame_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, WAIT} ame_state_e;

    localparam int AME_PIPE_DEPTH = 3;
    localparam int AME_NUM_PROD = 27;

    // Products 0..20 cover the A upper triangle row by row; 21..26 are ci*r (column 6).
    localparam int AME_IDX_I [AME_NUM_PROD] = '{
        0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 4, 4, 5,
        0, 1, 2, 3, 4, 5
    };
    localparam int AME_IDX_J [AME_NUM_PROD] = '{
        0, 1, 2, 3, 4, 5, 1, 2, 3, 4, 5, 2, 3, 4, 5, 3, 4, 5, 4, 5, 5,
        6, 6, 6, 6, 6, 6
    };

    function automatic int ame_prod_num(input int r, input int c);
        int lo;
        int hi;
        lo = (r < c) ? r : c;
        hi = (r < c) ? c : r;
        return (c == 6) ? 21 + r : lo * 6 - (lo * (lo - 1)) / 2 + hi - lo;
    endfunction

endpackage

// File: rtl/ame_matrix_accum_mac.sv
// ame_num_mac: registered signed multiply feeding an accumulator with enable/clear.
// Clamps instead of wrapping when AME_MATRIX_ACCUM_SAT_EN is defined.
module ame_num_mac #(
    parameter int GRAD_BITS = 16,
    parameter int ACC_BITS  = 40
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        mul_en_i,
    input  logic                        acc_en_i,
    input  logic                        clr_i,
    input  logic signed [GRAD_BITS-1:0] a_i,
    input  logic signed [GRAD_BITS-1:0] b_i,
    output logic signed [ACC_BITS-1:0]  acc_o
`ifdef AME_MATRIX_ACCUM_SAT_EN
    ,
    output logic                        sat_o
`endif
);

    logic signed [2*GRAD_BITS-1:0] prod_q;
    logic signed [ACC_BITS-1:0]    acc_q;
    logic signed [ACC_BITS-1:0]    acc_d;

`ifdef AME_MATRIX_ACCUM_SAT_EN
    logic signed [ACC_BITS:0] sum;
    assign sum   = (ACC_BITS+1)'(acc_q) + (ACC_BITS+1)'(prod_q);
    assign sat_o = acc_en_i & (sum[ACC_BITS] != sum[ACC_BITS-1]);
    assign acc_d = sat_o ? {sum[ACC_BITS], {(ACC_BITS-1){~sum[ACC_BITS]}}} : sum[ACC_BITS-1:0];
`else
    assign acc_d = acc_q + ACC_BITS'(prod_q);
`endif

    assign acc_o = acc_q;

    always_ff @(posedge clk_i) begin
        if (mul_en_i) prod_q <= (2*GRAD_BITS)'(a_i) * (2*GRAD_BITS)'(b_i);
        if (rst_i || clr_i) acc_q <= '0;
        else if (acc_en_i) acc_q <= acc_d;
    end

endmodule

// File: rtl/ame_matrix_accum.sv
// ame_matrix_accum: streams gradient samples into the 6x7 affine normal-equation matrix.
// Define AME_MATRIX_ACCUM_SAT_EN for saturating accumulators and the sticky sat_flag_o.
module ame_matrix_accum
    import ame_pkg::*;
#(
    parameter int GRAD_BITS      = 16,
    parameter int ACC_BITS       = 40,
    parameter int COMP_DATA_BITS = 64
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   frame_init_i,
    input  logic                                   affine_param6_i,
    input  logic                                   sample_valid_i,
    output logic                                   sample_ready_o,
    input  logic                                   sample_last_i,
    input  logic [6:0][GRAD_BITS-1:0]              sample_data_i,
    output logic                                   comp_init_o,
    input  logic                                   comp_done_i,
    output logic [5:0][6:0][COMP_DATA_BITS-1:0]    comp_data_o,
    output logic                                   busy_o
`ifdef AME_MATRIX_ACCUM_SAT_EN
    ,
    output logic                                   sat_flag_o
`endif
);

    ame_state_e                 state_q, state_d;
    logic [1:0]                 cnt_q, cnt_d;
    logic                       mode6_q, in_vld_q, prod_vld_q, comp_init_q;
    logic                       start, load, accept;
    logic [6:0][GRAD_BITS-1:0]  in_data_q;
    logic signed [ACC_BITS-1:0] acc [AME_NUM_PROD];
    logic signed [ACC_BITS-1:0] comp_data_q [AME_NUM_PROD];

    assign sample_ready_o = state_q == ACCUM;
    assign accept         = sample_valid_i & sample_ready_o;
    assign busy_o         = state_q != IDLE;
    assign comp_init_o    = comp_init_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                start   = frame_init_i;
                state_d = frame_init_i ? ACCUM : IDLE;
            end
            ACCUM: begin
                cnt_d   = '0;
                state_d = (accept && sample_last_i) ? FLUSH : ACCUM;
            end
            FLUSH: begin
                cnt_d   = cnt_q + 2'd1;
                load    = cnt_q == 2'(AME_PIPE_DEPTH - 1);
                state_d = load ? WAIT : FLUSH;
            end
            default: state_d = comp_done_i ? IDLE : WAIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mode6_q     <= 1'b0;
            in_vld_q    <= 1'b0;
            prod_vld_q  <= 1'b0;
            comp_init_q <= 1'b0;
            comp_data_q <= '{default: '0};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_vld_q    <= accept;
            prod_vld_q  <= in_vld_q;
            comp_init_q <= load;
            if (start) mode6_q <= affine_param6_i;
            if (load) comp_data_q <= acc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) in_data_q <= sample_data_i;
    end

`ifdef AME_MATRIX_ACCUM_SAT_EN
    logic [AME_NUM_PROD-1:0] sat_vec;
    logic                    sat_q;
    assign sat_flag_o = sat_q;
    always_ff @(posedge clk_i) begin
        if (rst_i || start) sat_q <= 1'b0;
        else if (|sat_vec) sat_q <= 1'b1;
    end
`endif

    // In 4-param mode every product touching index 0 or 1 stays at its cleared zero.
    for (genvar k = 0; k < AME_NUM_PROD; k++) begin : g_mac
        ame_num_mac #(
            .GRAD_BITS(GRAD_BITS),
            .ACC_BITS (ACC_BITS)
        ) u_mac (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .mul_en_i(in_vld_q),
            .acc_en_i(prod_vld_q & (mode6_q | (AME_IDX_I[k] >= 2))),
            .clr_i   (start),
            .a_i     (in_data_q[AME_IDX_I[k]]),
            .b_i     (in_data_q[AME_IDX_J[k]]),
            .acc_o   (acc[k])
`ifdef AME_MATRIX_ACCUM_SAT_EN
            ,
            .sat_o   (sat_vec[k])
`endif
        );
    end

    for (genvar i = 0; i < 6; i++) begin : g_row
        for (genvar j = 0; j < 7; j++) begin : g_col
            assign comp_data_o[i][j] = COMP_DATA_BITS'(comp_data_q[ame_prod_num(i, j)]);
        end
    end

endmodule

// File: tb/tb_ame_matrix_accum.sv
// tb_ame_matrix_accum: directed stimulus with hand-computed expectations for ame_matrix_accum.
module tb_ame_matrix_accum;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    frame_init = 1'b0;
    logic                    affine6 = 1'b0;
    logic                    valid = 1'b0;
    logic                    ready;
    logic                    last = 1'b0;
    logic [6:0][15:0]        sdata = '0;
    logic                    comp_init;
    logic                    comp_done = 1'b0;
    logic [5:0][6:0][63:0]   comp_data;
    logic                    busy;
`ifdef AME_MATRIX_ACCUM_SAT_EN
    logic                    sat_flag;
`endif
    int                      checks = 0;
    int                      errors = 0;

    always #5 clk = ~clk;

    ame_matrix_accum #(
        .GRAD_BITS     (16),
        .ACC_BITS      (34),
        .COMP_DATA_BITS(64)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .frame_init_i   (frame_init),
        .affine_param6_i(affine6),
        .sample_valid_i (valid),
        .sample_ready_o (ready),
        .sample_last_i  (last),
        .sample_data_i  (sdata),
        .comp_init_o    (comp_init),
        .comp_done_i    (comp_done),
        .comp_data_o    (comp_data),
        .busy_o         (busy)
`ifdef AME_MATRIX_ACCUM_SAT_EN
        ,
        .sat_flag_o     (sat_flag)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input longint exp);
        checks++;
        assert (obs === 64'(exp)) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic m6);
        frame_init = 1'b1;
        affine6    = m6;
        tick();
        frame_init = 1'b0;
    endtask

    task automatic send(input int c0, input int c1, input int c2, input int c3,
                        input int c4, input int c5, input int r, input logic l);
        int n;
        logic seen;
        n     = 0;
        seen  = 1'b0;
        sdata = {16'(r), 16'(c5), 16'(c4), 16'(c3), 16'(c2), 16'(c1), 16'(c0)};
        last  = l;
        valid = 1'b1;
        while (!seen && n < 20) begin
            seen = ready;
            tick();
            n++;
        end
        valid = 1'b0;
        last  = 1'b0;
        if (!seen) chk("send_accept", 64'(seen), 1);
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (!comp_init && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 64'(n), 3);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", 64'(ready), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_init", 64'(comp_init), 0);
        chk("rst_a00", comp_data[0][0], 0);
        chk("rst_b5", comp_data[5][6], 0);

        // Samples offered in IDLE must be dropped.
        sdata = {7{16'd100}};
        valid = 1'b1;
        tick();
        tick();
        valid = 1'b0;
        chk("idle_no_accept", 64'(busy), 0);

        // Single sample, 6-param model.
        frame(1'b1);
        chk("accum_busy", 64'(busy), 1);
        chk("accum_ready", 64'(ready), 1);
        send(1, 2, 3, 4, 5, 6, 7, 1'b1);
        chk("flush_ready", 64'(ready), 0);
        chk("flush_init", 64'(comp_init), 0);
        wait_init("lat6");
        chk("a55", comp_data[5][5], 36);
        chk("a24", comp_data[2][4], 15);
        chk("a42", comp_data[4][2], 15);
        chk("b5", comp_data[5][6], 42);
        chk("a00", comp_data[0][0], 1);
`ifdef AME_MATRIX_ACCUM_SAT_EN
        chk("sat_clear", 64'(sat_flag), 0);
`endif
        tick();
        chk("init_pulse", 64'(comp_init), 0);
        chk("wait_busy", 64'(busy), 1);
        comp_done = 1'b1;
        tick();
        comp_done = 1'b0;
        chk("done_idle", 64'(busy), 0);

        // Same sample, 4-param model.
        frame(1'b0);
        send(1, 2, 3, 4, 5, 6, 7, 1'b1);
        wait_init("lat4");
        chk("p4_a22", comp_data[2][2], 9);
        chk("p4_b3", comp_data[3][6], 28);
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 7; j++)
                if (i < 2 || j < 2) chk($sformatf("p4_zero_%0d_%0d", i, j), comp_data[i][j], 0);
        comp_done = 1'b1;
        tick();
        comp_done = 1'b0;

        // 16 samples with gaps; stray init/done in ACCUM must be ignored.
        frame(1'b1);
        for (int s = 0; s < 16; s++) begin
            send(-1, 0, 0, 0, 0, 2, -3, s == 15);
            if (s == 3) frame_init = 1'b1;
            if (s == 7) comp_done = 1'b1;
            if (s < 15) tick();
            frame_init = 1'b0;
            comp_done  = 1'b0;
        end
        chk("gap_ready_low", 64'(ready), 0);
        comp_done = 1'b1;
        wait_init("lat16");
        chk("done_first_wait_busy", 64'(busy), 1);
        tick();
        comp_done = 1'b0;
        chk("done_first_wait_idle", 64'(busy), 0);
        chk("g_a00", comp_data[0][0], 16);
        chk("g_a05", comp_data[0][5], -32);
        chk("g_a50", comp_data[5][0], -32);
        chk("g_a55", comp_data[5][5], 64);
        chk("g_b0", comp_data[0][6], 48);
        chk("g_b5", comp_data[5][6], -96);
        tick();
        chk("idle_ready_low", 64'(ready), 0);

        // 16 * 32767^2 = 17178820624 exceeds the 34-bit signed range.
        frame(1'b1);
        for (int s = 0; s < 16; s++) send(32767, 0, 0, 0, 0, 0, 0, s == 15);
        wait_init("lat_wrap");
`ifdef AME_MATRIX_ACCUM_SAT_EN
        chk("sat_a00", comp_data[0][0], 64'sd8589934591);
        chk("sat_flag", 64'(sat_flag), 1);
`else
        chk("wrap_a00", comp_data[0][0], -64'sd1048560);
`endif
        chk("wrap_b0", comp_data[0][6], 0);
        comp_done = 1'b1;
        tick();
        comp_done = 1'b0;

        // Reset mid-block discards partial sums.
        frame(1'b1);
        for (int s = 0; s < 5; s++) send(3, 5, 7, 9, 11, 13, 17, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_ready", 64'(ready), 0);
        chk("mid_rst_data", comp_data[0][0], 0);
        frame(1'b1);
`ifdef AME_MATRIX_ACCUM_SAT_EN
        chk("sat_cleared", 64'(sat_flag), 0);
`endif
        send(1, 1, 1, 1, 1, 1, 1, 1'b1);
        wait_init("lat_rst");
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 7; j++)
                chk($sformatf("ones_%0d_%0d", i, j), comp_data[i][j], 1);

        // Hold in WAIT with init attempts, then done and init together.
        for (int s = 0; s < 10; s++) begin
            frame_init = (s == 3);
            tick();
            chk("hold_busy", 64'(busy), 1);
            chk("hold_a23", comp_data[2][3], 1);
            chk("hold_b4", comp_data[4][6], 1);
        end
        frame_init = 1'b1;
        comp_done  = 1'b1;
        tick();
        frame_init = 1'b0;
        comp_done  = 1'b0;
        chk("both_busy", 64'(busy), 0);
        chk("both_ready", 64'(ready), 0);
        tick();
        tick();
        chk("both_still_idle", 64'(busy), 0);
        chk("both_data_held", comp_data[1][1], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
